// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and the baud divider helper
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int DATA_BITS = 8;
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous first-word-fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;
    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign full  = r_count == CW'(DEPTH);
    assign empty = r_count == '0;
    assign count = r_count;
    assign dout  = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffers incoming bytes in a FIFO and sends them as 8N1 UART frames
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       byte_dv,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int DIV  = calc_div(CLK_FREQ, BAUD);
    localparam int CW   = $clog2(DIV);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int BW   = $clog2(DATA_BITS);
    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_buf: clocks per bit must be at least 2");
        end
    endgenerate
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_dout;
    logic [CNTW-1:0]      w_count;
    tx_state_t            r_state;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_overflow;
    assign w_push    = ce & byte_dv & ~full;
    assign w_pop     = (r_state == IDLE) & ~w_empty;
    assign w_bit_end = r_baud == CW'(DIV - 1);
    assign tx        = r_tx;
    assign overflow  = r_overflow;
    assign busy      = (r_state != IDLE) | (w_count != '0);
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (byte_in),
        .dout  (w_dout),
        .full  (full),
        .empty (w_empty),
        .count (w_count)
    );
    // tx is registered from the state, so the line trails the FSM by one clock
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= ce & byte_dv & full;
            r_tx       <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
            r_baud     <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_shift <= w_dout;
                    r_state <= START;
                end
                START: if (w_bit_end) begin
                    r_bit   <= '0;
                    r_state <= DATA;
                end
                DATA: if (w_bit_end) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == BW'(DATA_BITS - 1)) r_state <= STOP;
                end
                STOP: if (w_bit_end) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
Downstream stage of the word-to-byte serialiser. It accepts the byte stream (byte_dv/byte_in, qualified by ce), buffers it in a small synchronous FIFO, and transmits each byte as an 8N1 UART frame on tx. It absorbs back-to-back byte bursts, such as the two-byte burst from each 16-bit word, that arrive far faster than the line rate.

Parameters:
CLK_FREQ, 100000000, clk frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = round(CLK_FREQ/BAUD) clocks per bit, DIV >= 2 required
DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
ce  in  1  clock enable qualifying byte_dv/byte_in; TX engine runs regardless of ce
byte_dv  in  1  byte valid; write attempt when ce=1 and byte_dv=1
byte_in  in  8  byte to transmit
tx  out  1  UART serial line, idle high
busy  out  1  1 while a frame is on the line or FIFO non-empty
full  out  1  FIFO holds DEPTH entries
overflow  out  1  one-cycle pulse: write attempted while full, byte dropped

Behaviour:
- Reset (rst=0 at a rising edge): tx=1, busy=0, full=0, overflow=0, FIFO pointers/count=0, FSM=IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame immediately (tx high on the next edge) and flushes the FIFO.
- Write: on each edge with ce&byte_dv&!full, byte_in is pushed. If full at that edge, nothing is pushed and overflow=1 for exactly that next cycle. full reflects the registered count: a pop on the same edge does not unblock a write.
- Simultaneous push and pop: both happen and count is unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts DIV clocks, then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for DIV clocks, then go to IDLE.
- Baud counter counts 0..DIV-1 and restarts on every state entry. There is no free-running tick, so the start bit is never shortened.
- Latency: byte pushed at edge n, popped by IDLE at edge n+1, tx falls at edge n+2.
- Back-to-back frames: one IDLE cycle between the stop bit and the next start bit, so frame period = 10*DIV+1 clocks.
- busy = (FSM != IDLE) | (count != 0). It is registered-state derived with no extra latency.
- ce=0 blocks writes only. Transmission continues.
- Width rules:
  - count is $clog2(DEPTH)+1 bits.
  - baud counter is $clog2(DIV) bits.
  - DIV computed at elaboration; if DIV < 2, elaboration fails via $error.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE, START, DATA, STOP)
  - function calc_div(CLK_FREQ, BAUD) with rounding
  - constant DATA_BITS=8
- One sub-module, sync_fifo (DEPTH, WIDTH=8): push, pop, din, dout (head, first-word fall-through), full, empty, count; synchronous active-low rst.
- The FSM, baud counter and shifter live in uart_tx_buf.

Test Plan:
Use CLK_FREQ=1000000, BAUD=100000 (DIV=10), DEPTH=4 unless noted.
1. Single byte: push 0xA5 at edge n -> tx low edges n+2..n+11, then bits 1,0,1,0,0,1,0,1 each 10 clocks, stop high 10 clocks; busy falls after stop; overflow never set.
2. Word burst: byte_dv high two cycles with 0x34 then 0x12 -> two frames (0x34 first), second start bit exactly 101 clocks after the first; full never asserted.
3. Overflow: push 6 bytes 0x01..0x06 on consecutive cycles -> 0x01 popped on the next edge, 0x02..0x05 fill the FIFO, full=1, 0x06 dropped with one overflow pulse; line output 0x01..0x05.
4. ce gating: byte_dv=1 with ce=0 for 5 cycles, byte 0x55 -> no push, tx stays 1, busy=0. Then ce=1 for one cycle -> exactly one 0x55 frame.
5. Reset mid-frame: rst=0 during DATA bit 3 of 0xFF with 2 bytes queued -> tx=1 next edge, busy=0, full=0; after release no frames are emitted.
6. Simultaneous push/pop at full: DEPTH=4 full, push coinciding with IDLE pop -> push rejected with overflow pulse, count goes 4->3.
